// File: rtl/jesd204_pkg.sv
// Shared JESD204 link-layer types and constants, common to the RX and TX control units.
package jesd204_pkg;

  typedef enum logic [4:0] {
    SM_IDLE       = 5'b00001,
    SM_LMFC_ALIGN = 5'b00010,
    SM_CGS        = 5'b00100,
    SM_ILA        = 5'b01000,
    SM_DATA       = 5'b10000
  } sm_t;

  localparam int CGS_K_CNT = 4;
  localparam int ERR_W     = 8;

endpackage

// File: rtl/rx_cu_lane.sv
// Per-lane receive tracking: consecutive /K/ counter for CGS lock and sticky ILA-done flag.
module rx_cu_lane
  import jesd204_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cgs_st_i,
  input  logic ila_st_i,
  input  logic k_det_i,
  input  logic ila_end_i,
  input  logic lane_en_i,
  output logic cgs_ok_o,
  output logic ila_done_o
);

  logic [2:0] k_cnt_q, k_cnt_d;
  logic       ila_done_q, ila_done_d;

  // Any non-K word breaks the run; the counter only lives while in CGS.
  always_comb begin
    k_cnt_d = '0;
    if (cgs_st_i && k_det_i)
      k_cnt_d = (k_cnt_q == 3'(CGS_K_CNT)) ? k_cnt_q : k_cnt_q + 3'd1;
    ila_done_d = ila_st_i & (ila_done_q | (ila_end_i & lane_en_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_cnt_q    <= '0;
      ila_done_q <= 1'b0;
    end else begin
      k_cnt_q    <= k_cnt_d;
      ila_done_q <= ila_done_d;
    end
  end

  assign cgs_ok_o   = (k_cnt_q == 3'(CGS_K_CNT));
  assign ila_done_o = ila_done_q;

endmodule

// File: rtl/rx_cu.sv
// JESD204 RX link control: CGS/ILA/DATA sequencing, SYNC generation, ILA timeout and error-driven resync.
module rx_cu
  import jesd204_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [LANES-1:0] LANE_EN,
  input  logic [2:0]       SUBCLASSV,
  input  logic             LMFC_SYNCED,
  input  logic [3:0]       LMFC_ME,
  input  logic [LANES-1:0] K_DET,
  input  logic [LANES-1:0] ILA_END,
  input  logic [LANES-1:0] ERR,
  input  logic [ERR_W-1:0] ILA_TMO,
  input  logic [ERR_W-1:0] ERR_THRESH,
  output logic             SYNC,
  output logic             LMFC_EN,
  output logic [LANES-1:0] ILA_EN,
  output logic [LANES-1:0] DATA_EN,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

  sm_t              state_q, state_d;
  logic [ERR_W-1:0] tmo_q, tmo_d, err_q, err_d;
  logic [LANES-1:0] cgs_ok, ila_done;
  logic             lmfc_edge, gate, all_ok, all_done;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rx_cu_lane u_lane (
      .clk_i      (CLK),
      .rst_ni     (RST_n),
      .cgs_st_i   (state_q == SM_CGS),
      .ila_st_i   (state_q == SM_ILA),
      .k_det_i    (K_DET[i]),
      .ila_end_i  (ILA_END[i]),
      .lane_en_i  (LANE_EN[i]),
      .cgs_ok_o   (cgs_ok[i]),
      .ila_done_o (ila_done[i])
    );
  end

  assign lmfc_edge = |LMFC_ME;
  assign gate      = (SUBCLASSV == 3'd0) || lmfc_edge;
  // Disabled lanes count as satisfied; an empty mask must not leave CGS.
  assign all_ok    = (LANE_EN != '0) && (&(cgs_ok | ~LANE_EN));
  assign all_done  = &(ila_done | ~LANE_EN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SM_IDLE:       state_d = (SUBCLASSV == 3'd0) ? SM_CGS : SM_LMFC_ALIGN;
      SM_LMFC_ALIGN: if (LMFC_SYNCED) state_d = SM_CGS;
      SM_CGS:        if (all_ok && gate) state_d = SM_ILA;
      SM_ILA: begin
        if (all_done && gate)
          state_d = SM_DATA;
        else if ((ILA_TMO != '0) && (tmo_q >= ILA_TMO))
          state_d = SM_IDLE;
      end
      SM_DATA:       if ((ERR_THRESH != '0) && (err_q >= ERR_THRESH)) state_d = SM_IDLE;
      default:       state_d = SM_IDLE;
    endcase
  end

  always_comb begin
    tmo_d = '0;
    err_d = '0;
    if (state_q == SM_ILA)
      tmo_d = (lmfc_edge && tmo_q != CNT_MAX) ? tmo_q + 1'b1 : tmo_q;
    if (state_q == SM_DATA)
      err_d = ((|(ERR & LANE_EN)) && err_q != CNT_MAX) ? err_q + 1'b1 : err_q;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= SM_IDLE;
      tmo_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign LMFC_EN = (state_q != SM_IDLE);
  assign SYNC    = (state_q == SM_ILA) || (state_q == SM_DATA);
  assign ILA_EN  = LANE_EN & {LANES{SYNC}};
  assign DATA_EN = LANE_EN & {LANES{state_q == SM_DATA}};
  assign ERR_CNT = err_q;

endmodule

// File: tb/tb_rx_cu.sv
// Randomized scoreboard bench for rx_cu (2 lanes) against a link-level reference model.
module tb_rx_cu;

  localparam int L = 2;
  localparam int M_IDLE = 0, M_ALIGN = 1, M_CGS = 2, M_ILA = 3, M_DATA = 4;

  logic         clk = 0, rst_n = 1;
  logic [L-1:0] lane_en = '0, k_det = '0, ila_end = '0, err = '0;
  logic [2:0]   subclassv = '0;
  logic         lmfc_synced = 0;
  logic [3:0]   lmfc_me = '0;
  logic [7:0]   ila_tmo = '0, err_thresh = '0;
  logic         sync, lmfc_en;
  logic [L-1:0] ila_en, data_en;
  logic [7:0]   err_cnt;

  rx_cu #(.LANES(L)) dut (
    .CLK(clk), .RST_n(rst_n), .LANE_EN(lane_en), .SUBCLASSV(subclassv),
    .LMFC_SYNCED(lmfc_synced), .LMFC_ME(lmfc_me), .K_DET(k_det), .ILA_END(ila_end),
    .ERR(err), .ILA_TMO(ila_tmo), .ERR_THRESH(err_thresh), .SYNC(sync),
    .LMFC_EN(lmfc_en), .ILA_EN(ila_en), .DATA_EN(data_en), .ERR_CNT(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sync, lmfc;
    logic [1:0] ila, data;
    logic [7:0] ec;
    int         cyc;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0, cyc = 0, lcnt = 0, per = 8;
  bit rel_pend = 0;

  // Reference model: link state plus per-lane run lengths and done flags.
  int st, kc[L], tmo_c, ec;
  bit dn[L];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
  endtask

  function automatic void model_reset();
    st = M_IDLE; tmo_c = 0; ec = 0;
    for (int i = 0; i < L; i++) begin kc[i] = 0; dn[i] = 0; end
  endfunction

  function automatic void model_step();
    bit edge_s, gate, ok, done;
    int nst;
    edge_s = (lmfc_me != 0);
    gate = (subclassv == 0) || edge_s;
    ok = (lane_en != 0);
    done = 1;
    for (int i = 0; i < L; i++) begin
      if (lane_en[i] && kc[i] < 4) ok = 0;
      if (lane_en[i] && !dn[i]) done = 0;
    end
    nst = st;
    case (st)
      M_IDLE:  nst = (subclassv == 0) ? M_CGS : M_ALIGN;
      M_ALIGN: if (lmfc_synced) nst = M_CGS;
      M_CGS:   if (ok && gate) nst = M_ILA;
      M_ILA:   if (done && gate) nst = M_DATA;
               else if (ila_tmo != 0 && tmo_c >= int'(ila_tmo)) nst = M_IDLE;
      M_DATA:  if (err_thresh != 0 && ec >= int'(err_thresh)) nst = M_IDLE;
      default: nst = M_IDLE;
    endcase
    for (int i = 0; i < L; i++) begin
      kc[i] = (st == M_CGS && k_det[i]) ? ((kc[i] + 1 > 4) ? 4 : kc[i] + 1) : 0;
      dn[i] = (st == M_ILA) && (dn[i] || (ila_end[i] && lane_en[i]));
    end
    tmo_c = (st != M_ILA) ? 0 : (edge_s && tmo_c < 255) ? tmo_c + 1 : tmo_c;
    ec    = (st != M_DATA) ? 0 : ((err & lane_en) != 0 && ec < 255) ? ec + 1 : ec;
    st = nst;
  endfunction

  // Reset asserted between edges; outputs must clear with no clock.
  task automatic do_reset();
    @(negedge clk);
    #4 rst_n = 0;
    #1;
    chk("async_rst_sync", sync, 0);
    chk("async_rst_lmfc_en", lmfc_en, 0);
    chk("async_rst_ila_en", ila_en, 0);
    chk("async_rst_data_en", data_en, 0);
    chk("async_rst_err_cnt", err_cnt, 0);
    model_reset();
    rel_pend = 1;
  endtask

  task automatic cycle(input int pk, input int pie, input logic [1:0] iem,
                       input int perr, input int enchg);
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rel_pend) begin rst_n = 1; rel_pend = 0; end
    if ($urandom_range(99) < enchg) lane_en = 2'($urandom_range(3));
    for (int i = 0; i < L; i++) begin
      k_det[i]   = ($urandom_range(99) < pk);
      ila_end[i] = iem[i] && ($urandom_range(99) < pie);
      err[i]     = ($urandom_range(99) < perr);
    end
    lcnt++;
    lmfc_me = (lcnt % per == 0) ? 4'(1 << $urandom_range(3)) : 4'd0;
    lmfc_synced = ($urandom_range(99) < 70);
    e.sync = (st == M_ILA || st == M_DATA);
    e.lmfc = (st != M_IDLE);
    e.ila  = e.sync ? lane_en : 2'b00;
    e.data = (st == M_DATA) ? lane_en : 2'b00;
    e.ec   = 8'(ec);
    e.cyc  = cyc;
    q.push_back(e);
    @(posedge clk);
    if (rst_n) model_step();
  endtask

  task automatic run_phase(input int sub, input int tmo, input int thr, input int p,
                           input logic [1:0] en, input int enchg, input int pk,
                           input int pie, input logic [1:0] iem, input int perr, input int n);
    do_reset();
    subclassv = 3'(sub); ila_tmo = 8'(tmo); err_thresh = 8'(thr);
    per = p; lane_en = en;
    for (int c = 0; c < n; c++) cycle(pk, pie, iem, perr, enchg);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("SYNC", sync, e.sync);
        chk("LMFC_EN", lmfc_en, e.lmfc);
        chk("ILA_EN", ila_en, e.ila);
        chk("DATA_EN", data_en, e.data);
        chk("ERR_CNT", err_cnt, e.ec);
      end
    end
  end

  initial begin : driver
    model_reset();
    //        sub tmo thr per  en  chg  pk  pie iem   perr  n
    run_phase(0,  0,  0,  8,  2'b11, 0, 95, 30, 2'b11, 0,  200);  // subclass 0 bring-up
    run_phase(1,  0,  8,  8,  2'b11, 0, 90, 20, 2'b11, 5,  400);  // subclass 1, LMFC-gated
    run_phase(2,  3,  0,  8,  2'b11, 0, 95, 20, 2'b01, 0,  400);  // ILA timeout, lane 1 silent
    run_phase(0,  2,  0,  5,  2'b11, 0, 95, 6,  2'b11, 0,  500);  // done/timeout races
    run_phase(0,  0,  5,  8,  2'b01, 2, 92, 30, 2'b11, 30, 500);  // threshold resync, masked lanes
    run_phase(0,  0,  0,  8,  2'b11, 0, 98, 50, 2'b11, 90, 700);  // ERR_CNT saturation
    run_phase(1,  4,  3,  6,  2'b10, 5, 85, 15, 2'b11, 10, 400);  // mask churn incl. empty
    do_reset();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
